// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multi-cycle control unit (master) and the
// shared datapath / instruction register / memory (slave).
interface multicycle_control_unit_if #(
    parameter int unsigned OPCODE_W = 4,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned CNT_W    = 16
);
    logic [OPCODE_W-1:0] OPCODE;
    logic                Zero;
    logic                MemReady;

    logic                PCEn;
    logic                IorD;
    logic                IRWrite;
    logic                MemRead;
    logic                MemWrite;
    logic                RegDst;
    logic                MemToReg;
    logic                RegWrite;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [ALUOP_W-1:0]  ALUOp;
    logic                Retire;
    logic [CNT_W-1:0]    RetireCount;
    logic                Fault;
    logic [1:0]          FaultCode;
    logic [3:0]          State;

    modport master (
        input  OPCODE, Zero, MemReady,
        output PCEn, IorD, IRWrite, MemRead, MemWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, Retire, RetireCount,
               Fault, FaultCode, State
    );

    modport slave (
        output OPCODE, Zero, MemReady,
        input  PCEn, IorD, IRWrite, MemRead, MemWrite, RegDst, MemToReg,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, Retire, RetireCount,
               Fault, FaultCode, State
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control unit for the 16-bit CPU: sequences fetch, decode,
// execute, memory and writeback, handshakes with a variable-latency memory,
// resolves BEQ/BNE and latches a sticky fault on illegal opcodes or timeouts.
module multicycle_control_unit #(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic Clock,
    input  logic Reset,
    multicycle_control_unit_if.master bus
);
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd15
    } state_t;

    state_t             state;
    state_t             nxt;
    logic [1:0]         nxt_code;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [3:0]         op;
    logic               op_hi_clear;
    logic               mem_wait;
    logic               at_limit;
    logic               branch_take;
    logic               retire_c;
    logic               run;

    logic               iord_q;
    logic               memread_q;
    logic               memwrite_q;
    logic               regdst_q;
    logic               memtoreg_q;
    logic               regwrite_q;
    logic               srca_q;
    logic [1:0]         srcb_q;
    logic [1:0]         aluop_q;
    logic               retire_q;
    logic               fault_q;
    logic [1:0]         fault_code_q;
    logic [CNT_W-1:0]   retire_cnt;

    assign op          = bus.OPCODE[3:0];
    assign op_hi_clear = ((bus.OPCODE >> 4) == '0);
    assign mem_wait    = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign at_limit    = (wait_cnt == WAIT_W'(MEM_TIMEOUT));
    assign branch_take = (state == S_BRANCH) && (op[0] ? bus.Zero : !bus.Zero);
    assign run         = !Reset;
    assign retire_c    = run && (retire_q || ((state == S_MEM_WR) && bus.MemReady));

    // Next-state selection; a memory answer in the limit cycle beats the timeout.
    always_comb begin
        nxt      = state;
        nxt_code = 2'b00;
        case (state)
            S_FETCH: begin
                if (bus.MemReady) begin
                    nxt = S_DECODE;
                end else if (at_limit) begin
                    nxt      = S_FAULT;
                    nxt_code = 2'b10;
                end
            end
            S_DECODE: begin
                nxt      = S_FAULT;
                nxt_code = 2'b01;
                if (op_hi_clear) begin
                    case (op)
                        4'b0000, 4'b0001, 4'b0010: begin nxt = S_EXEC_R;   nxt_code = 2'b00; end
                        4'b1001, 4'b1010, 4'b1011: begin nxt = S_EXEC_I;   nxt_code = 2'b00; end
                        4'b1100, 4'b1101:          begin nxt = S_MEM_ADDR; nxt_code = 2'b00; end
                        4'b1110, 4'b1111:          begin nxt = S_BRANCH;   nxt_code = 2'b00; end
                        default: ;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
            S_MEM_ADDR:         nxt = op[0] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD, S_MEM_WR: begin
                if (bus.MemReady) begin
                    nxt = (state == S_MEM_RD) ? S_WB_MEM : S_FETCH;
                end else if (at_limit) begin
                    nxt      = S_FAULT;
                    nxt_code = 2'b10;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: nxt = S_FETCH;
            S_FAULT:            nxt = S_FAULT;
            default:            nxt = S_FETCH;
        endcase
    end

    // State, memory wait counter, sticky fault and retire counter.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= S_FETCH;
            wait_cnt     <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
            retire_cnt   <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                wait_cnt <= '0;
            end else if (mem_wait && !bus.MemReady) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if ((nxt == S_FAULT) && (state != S_FAULT)) begin
                fault_q      <= 1'b1;
                fault_code_q <= nxt_code;
            end
            if (retire_c) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    // Moore controls registered from the state being entered.
    always_ff @(posedge Clock) begin
        iord_q     <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
        regdst_q   <= 1'b0;
        memtoreg_q <= 1'b0;
        regwrite_q <= 1'b0;
        srca_q     <= 1'b0;
        srcb_q     <= 2'b00;
        aluop_q    <= 2'b00;
        retire_q   <= 1'b0;
        if (Reset) begin
            memread_q <= 1'b1;
            srcb_q    <= 2'b01;
        end else begin
            case (nxt)
                S_FETCH:    begin memread_q <= 1'b1; srcb_q <= 2'b01; end
                S_DECODE:   srcb_q <= 2'b10;
                S_EXEC_R:   begin srca_q <= 1'b1; aluop_q <= 2'b10; end
                S_EXEC_I:   begin srca_q <= 1'b1; srcb_q <= 2'b10; aluop_q <= 2'b11; end
                S_MEM_ADDR: begin srca_q <= 1'b1; srcb_q <= 2'b10; end
                S_MEM_RD:   begin iord_q <= 1'b1; memread_q <= 1'b1; end
                S_MEM_WR:   begin iord_q <= 1'b1; memwrite_q <= 1'b1; end
                S_WB_ALU:   begin regwrite_q <= 1'b1; retire_q <= 1'b1; regdst_q <= (state == S_EXEC_R); end
                S_WB_MEM:   begin regwrite_q <= 1'b1; memtoreg_q <= 1'b1; retire_q <= 1'b1; end
                S_BRANCH:   begin srca_q <= 1'b1; aluop_q <= 2'b01; retire_q <= 1'b1; end
                default: ;
            endcase
        end
    end

    assign bus.PCEn        = run && (((state == S_FETCH) && bus.MemReady) || branch_take);
    assign bus.IRWrite     = run && (state == S_FETCH) && bus.MemReady;
    assign bus.IorD        = run && iord_q;
    assign bus.MemRead     = run && memread_q;
    assign bus.MemWrite    = run && memwrite_q;
    assign bus.RegDst      = run && regdst_q;
    assign bus.MemToReg    = run && memtoreg_q;
    assign bus.RegWrite    = run && regwrite_q;
    assign bus.ALUSrcA     = run && srca_q;
    assign bus.ALUSrcB     = run ? srcb_q : 2'b00;
    assign bus.ALUOp       = run ? ALUOP_W'(aluop_q) : '0;
    assign bus.Retire      = retire_c;
    assign bus.RetireCount = retire_cnt;
    assign bus.Fault       = fault_q;
    assign bus.FaultCode   = fault_code_q;
    assign bus.State       = state;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: the driver plays each instruction as a cycle timeline
// derived from the state table, queueing per-cycle expectations and expected
// retire latencies; a negedge monitor pops and compares.
module tb_multicycle_control_unit;
    localparam int unsigned OPCODE_W    = 4;
    localparam int unsigned ALUOP_W     = 2;
    localparam int unsigned MEM_TIMEOUT = 15;
    localparam int unsigned CNT_W       = 5;
    localparam int unsigned VEC_W       = 4 + 14 + 1 + 2 + CNT_W;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_EXEC_R = 2, ST_EXEC_I = 3,
                   ST_MEM_ADDR = 4, ST_MEM_RD = 5, ST_MEM_WR = 6, ST_WB_ALU = 7,
                   ST_WB_MEM = 8, ST_BRANCH = 9, ST_FAULT = 15;

    typedef logic [VEC_W-1:0] vec_t;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    multicycle_control_unit_if #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(
        .OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    vec_t cyc_q[$];
    int   lat_q[$];
    bit   run_on = 1'b0;
    int   lat_cyc = 0;

    logic [3:0]       cur_op = 4'd0;
    logic             cur_rd = 1'b0;
    logic             exp_fault = 1'b0;
    logic [1:0]       exp_fcode = 2'b00;
    logic [CNT_W-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // {PCEn,IorD,IRWrite,MemRead,MemWrite,RegDst,MemToReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,Retire}
    function automatic logic [13:0] exp_ctrl(input int st, input logic mr, input logic z,
                                             input logic [3:0] op, input logic rd);
        logic pcen, iord, irw, mrd, mwr, rdst, m2r, rw, srca, ret;
        logic [1:0] srcb, aluop;
        {pcen, iord, irw, mrd, mwr, rdst, m2r, rw, srca, ret} = '0;
        srcb  = 2'b00;
        aluop = 2'b00;
        case (st)
            ST_FETCH:    begin mrd = 1; srcb = 2'b01; irw = mr; pcen = mr; end
            ST_DECODE:   srcb = 2'b10;
            ST_EXEC_R:   begin srca = 1; aluop = 2'b10; end
            ST_EXEC_I:   begin srca = 1; srcb = 2'b10; aluop = 2'b11; end
            ST_MEM_ADDR: begin srca = 1; srcb = 2'b10; end
            ST_MEM_RD:   begin iord = 1; mrd = 1; end
            ST_MEM_WR:   begin iord = 1; mwr = 1; ret = mr; end
            ST_WB_ALU:   begin rw = 1; rdst = rd; ret = 1; end
            ST_WB_MEM:   begin rw = 1; m2r = 1; ret = 1; end
            ST_BRANCH:   begin srca = 1; aluop = 2'b01; ret = 1; pcen = (op == 4'b1111) ? z : !z; end
            default: ;
        endcase
        return {pcen, iord, irw, mrd, mwr, rdst, m2r, rw, srca, srcb, aluop, ret};
    endfunction

    // One clock cycle in state st: queue the expectation, drive inputs, advance.
    task automatic cyc(input int st, input logic mr, input logic z, input logic rst);
        logic [13:0] c;
        c = rst ? 14'd0 : exp_ctrl(st, mr, z, cur_op, cur_rd);
        cyc_q.push_back({4'(st), c, exp_fault, exp_fcode, exp_cnt});
        Reset        = rst;
        bus.MemReady = mr;
        bus.Zero     = z;
        bus.OPCODE   = OPCODE_W'(cur_op);
        @(posedge Clock);
        #1;
        if (rst) begin
            exp_fault = 1'b0;
            exp_fcode = 2'b00;
            exp_cnt   = '0;
        end else if (c[0]) begin
            exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    // A memory phase tolerates MEM_TIMEOUT unanswered cycles; the next one faults.
    task automatic mem_phase(input int st, input int n, output bit to);
        to = 1'b0;
        for (int i = 0; i < n; i++) begin
            cyc(st, 1'b0, rb(), 1'b0);
            if (i == int'(MEM_TIMEOUT)) begin
                to = 1'b1;
                return;
            end
        end
        cyc(st, 1'b1, rb(), 1'b0);
    endtask

    task automatic fault_hold(input logic [1:0] code, input int n);
        exp_fault = 1'b1;
        exp_fcode = code;
        repeat (n) cyc(ST_FAULT, rb(), rb(), 1'b0);
        cyc(ST_FAULT, rb(), rb(), 1'b1);
    endtask

    // fw/mw: unanswered cycles before MemReady in fetch / memory access.
    task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                             input int hold, input logic bz);
        int  kind;
        bit  to;
        bit  will_fault;
        int  lat;
        case (op)
            4'd0, 4'd1, 4'd2:    kind = 0;
            4'd9, 4'd10, 4'd11:  kind = 1;
            4'd12:               kind = 2;
            4'd13:               kind = 3;
            4'd14, 4'd15:        kind = 4;
            default:             kind = 5;
        endcase
        cur_op = op;
        cur_rd = (kind == 0);
        will_fault = (kind == 5) || (fw > int'(MEM_TIMEOUT)) ||
                     ((kind == 2 || kind == 3) && mw > int'(MEM_TIMEOUT));
        if (!will_fault) begin
            case (kind)
                0, 1:    lat = 4;
                2:       lat = 5 + mw;
                3:       lat = 4 + mw;
                default: lat = 3;
            endcase
            lat_q.push_back(lat + fw);
        end
        mem_phase(ST_FETCH, fw, to);
        if (to) begin
            fault_hold(2'b10, hold);
            return;
        end
        cyc(ST_DECODE, rb(), rb(), 1'b0);
        case (kind)
            0: begin cyc(ST_EXEC_R, rb(), rb(), 1'b0); cyc(ST_WB_ALU, rb(), rb(), 1'b0); end
            1: begin cyc(ST_EXEC_I, rb(), rb(), 1'b0); cyc(ST_WB_ALU, rb(), rb(), 1'b0); end
            2: begin
                cyc(ST_MEM_ADDR, rb(), rb(), 1'b0);
                mem_phase(ST_MEM_RD, mw, to);
                if (to) fault_hold(2'b10, hold);
                else    cyc(ST_WB_MEM, rb(), rb(), 1'b0);
            end
            3: begin
                cyc(ST_MEM_ADDR, rb(), rb(), 1'b0);
                mem_phase(ST_MEM_WR, mw, to);
                if (to) fault_hold(2'b10, hold);
            end
            4: cyc(ST_BRANCH, rb(), bz, 1'b0);
            default: fault_hold(2'b01, hold);
        endcase
    endtask

    task automatic legal_random();
        logic [3:0] legal [10] = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        run_instr(legal[$urandom_range(0, 9)], int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 4)), 2, rb());
    endtask

    // Monitor: per-cycle comparison plus retire latency on each Retire pulse.
    always @(negedge Clock) begin
        vec_t e;
        vec_t a;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            a = {bus.State, bus.PCEn, bus.IorD, bus.IRWrite, bus.MemRead, bus.MemWrite,
                 bus.RegDst, bus.MemToReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                 bus.ALUOp, bus.Retire, bus.Fault, bus.FaultCode, bus.RetireCount};
            check("cycle", 64'(a), 64'(e));
        end else if (run_on) begin
            checks++;
            errors++;
            $display("FAIL cycle_queue at %0t: got empty expected an entry", $time);
        end
        if (Reset) begin
            lat_cyc = 0;
        end else begin
            lat_cyc++;
            if (bus.Retire) begin
                if (lat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL retire at %0t: got Retire=1 expected no retire", $time);
                end else begin
                    check("latency", 64'(lat_cyc), 64'(lat_q.pop_front()));
                end
                lat_cyc = 0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        bus.MemReady = 1'b0;
        bus.Zero     = 1'b0;
        bus.OPCODE   = '0;
        @(posedge Clock);
        #1;
        run_on = 1'b1;
        cyc(ST_FETCH, 1'b0, 1'b0, 1'b1);

        run_instr(4'b0001, 0, 0, 0, 1'b0);   // R-type, 4 cycles
        run_instr(4'b1100, 0, 3, 0, 1'b0);   // LW with 3 wait cycles, 8 cycles
        run_instr(4'b1111, 0, 0, 0, 1'b1);   // BEQ taken
        run_instr(4'b1110, 0, 0, 0, 1'b1);   // BNE not taken
        run_instr(4'b1101, 1, 2, 0, 1'b0);   // SW
        run_instr(4'b1010, 0, 0, 0, 1'b0);   // I-type
        run_instr(4'b0101, 0, 0, 20, 1'b0);  // illegal opcode, held 20 cycles
        run_instr(4'b0001, 30, 0, 3, 1'b0);  // fetch timeout
        run_instr(4'b0001, 15, 0, 0, 1'b0);  // ready exactly at the limit
        run_instr(4'b1100, 0, 20, 2, 1'b0);  // MEM_RD timeout
        run_instr(4'b1101, 0, 15, 0, 1'b0);  // MEM_WR ready at the limit

        cyc(ST_FETCH, 1'b0, 1'b0, 1'b1);
        repeat (34) legal_random();           // RetireCount wraps past 2^CNT_W-1

        cur_op = 4'b1101;                     // reset during MEM_WR aborts the store
        cur_rd = 1'b0;
        cyc(ST_FETCH, 1'b1, rb(), 1'b0);
        cyc(ST_DECODE, rb(), rb(), 1'b0);
        cyc(ST_MEM_ADDR, rb(), rb(), 1'b0);
        cyc(ST_MEM_WR, 1'b0, rb(), 1'b0);
        cyc(ST_MEM_WR, 1'b1, rb(), 1'b1);
        run_instr(4'b0000, 0, 0, 0, 1'b0);

        repeat (40) begin
            if ($urandom_range(0, 9) == 0)
                run_instr(4'($urandom_range(3, 8)), 0, 0, 2, 1'b0);
            else if ($urandom_range(0, 19) == 0)
                run_instr(4'b0010, int'($urandom_range(16, 18)), 0, 2, 1'b0);
            else
                legal_random();
        end

        run_on = 1'b0;
        @(negedge Clock);
        check("cycle_queue_drained", 64'(cyc_q.size()), 64'd0);
        check("retire_queue_drained", 64'(lat_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
